// File: rtl/nand_share_sched_if.sv
// Bundle of request/operand/result signals between requesters and the
// shared-NAND scheduler, with one modport for each side.
interface nand_share_sched_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [W-1:0]   gy;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   ga;
    logic [W-1:0]   gb;
    logic [W-1:0]   y;
    logic [N-1:0]   done;

    modport master (
        output req, a_in, b_in, gy,
        input  gnt, busy, ga, gb, y, done
    );

    modport slave (
        input  req, a_in, b_in, gy,
        output gnt, busy, ga, gb, y, done
    );
endinterface

// File: rtl/nand_share_sched.sv
// Round-robin scheduler sharing one W-bit NAND gate among N requesters:
// latches operands, holds them SETTLE clocks, then captures the gate output.
module nand_share_sched #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              clr,
    nand_share_sched_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic           busy_q, busy_d;
    logic [W-1:0]   ga_q, ga_d;
    logic [W-1:0]   gb_q, gb_d;
    logic [W-1:0]   y_q, y_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  sel_q, sel_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   avail;
    logic           found;
    logic [PW-1:0]  pick;
    logic [PW-1:0]  idx;

    // The requester served last cycle (done_q) sits out this arbitration round.
    always_comb begin
        avail = bus.req & ~done_q;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_q) + k) % N);
            if (!found && avail[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        y_d     = y_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = N'(1) << pick;
                    busy_d  = 1'b1;
                    ga_d    = bus.a_in[int'(pick)*W +: W];
                    gb_d    = bus.b_in[int'(pick)*W +: W];
                    sel_d   = pick;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SETTLE - 1)) begin
                    y_d     = bus.gy;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (sel_q == PW'(N - 1)) ? '0 : sel_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            ga_q    <= '0;
            gb_q    <= '0;
            y_q     <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ga_q    <= ga_d;
            gb_q    <= gb_d;
            y_q     <= y_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.ga   = ga_q;
    assign bus.gb   = gb_q;
    assign bus.y    = y_q;
endmodule
